uart_rx_port: RTL

Serial receiver that deserialises an asynchronous 8N1 bit stream into a parallel byte. It holds that byte stable as an 8-bit value for one of the processor's input ports. It sits directly upstream of the input-port register/mux stage: `data_out` drives one 8-bit input port, and `{5'b0, overrun, frame_err, valid}` drives a second port so software can poll status. Software consumes a byte by pulsing `ack`, which is derived from an output-port write.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync2.sv | 26 ++
 rtl/uart_rx_port.sv | 125 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive port.
//   uart_rx_state_t : receiver FSM state encoding
//   UART_DATA_W     : width of one received character
//   ST_*            : bit positions of the status input port
//                     {5'b0, overrun, frame_err, valid}
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_rx_state_t;

    localparam int UART_DATA_W = 8;

    localparam int ST_VALID = 0;
    localparam int ST_FERR  = 1;
    localparam int ST_OVR   = 2;

endpackage

// File: rtl/sync2.sv
// sync2: generic 1-bit two-flop synchronizer.
//   clk   : destination clock
//   reset : synchronous active-high reset; both flops go to 1 so an idle
//           (high) serial line is not seen as a transition after reset
//   d     : asynchronous input
//   q     : synchronized output, 2 cycles behind d
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b1;
            q    <= 1'b1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_port.sv
// uart_rx_port: 8N1 serial receiver feeding two processor input ports.
//   clk       : system clock, rising edge
//   reset     : synchronous active-high reset
//   rx        : asynchronous serial line, idles high
//   ack       : one-cycle pulse from an output-port write; consumes the byte
//               and clears the sticky status bits
//   data_out  : last correctly framed byte, held until the next good byte
//   valid     : unconsumed byte present in data_out
//   frame_err : sticky, last frame had a low stop bit
//   overrun   : sticky, a byte was replaced before it was acked
// CLK_DIV is the number of clocks per serial bit (even, >= 4).
module uart_rx_port
    import uart_pkg::*;
#(
    parameter int CLK_DIV = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   ack,
    output logic [UART_DATA_W-1:0] data_out,
    output logic                   valid,
    output logic                   frame_err,
    output logic                   overrun
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLK_DIV - 1);

    logic                   rx_s;
    uart_rx_state_t         state;
    logic                   armed;
    logic [CW-1:0]          cnt;
    logic [2:0]             bitn;
    logic [UART_DATA_W-1:0] shreg;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            armed     <= 1'b0;
            cnt       <= '0;
            bitn      <= '0;
            shreg     <= '0;
            data_out  <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            // ack clears first; a same-cycle stop-bit result below overrides it
            if (ack) begin
                valid     <= 1'b0;
                frame_err <= 1'b0;
                overrun   <= 1'b0;
            end

            case (state)
                IDLE: begin
                    // a line that was never seen high (break, or low out of
                    // reset) must not be decoded as a run of 0x00 bytes
                    if (rx_s) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    // re-check the start bit at its midpoint; high means glitch
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!rx_s) begin
                            state <= DATA;
                            bitn  <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (cnt == FULL_M1) begin
                        shreg <= {rx_s, shreg[UART_DATA_W-1:1]};
                        cnt   <= '0;
                        bitn  <= bitn + 1'b1;
                        if (bitn == 3'd7) state <= STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (cnt == FULL_M1) begin
                        cnt   <= '0;
                        state <= IDLE;
                        if (rx_s) begin
                            data_out <= shreg;
                            valid    <= 1'b1;
                            if (valid && !ack) overrun <= 1'b1;
                        end else begin
                            // keep the previous byte; require idle before rearming
                            frame_err <= 1'b1;
                            armed     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
